// File: rtl/nibble_serial_sub_pkg.sv
// Shared ALU definitions for the nibble-serial subtractor: controller states and slice width.
package nibble_serial_sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/four_bit_sub.sv
// Combinational 4-bit subtract slice: diff = a + ~b + cin, with carry out and signed overflow.
module four_bit_sub
  import nibble_serial_sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] diff,
  output logic                cout,
  output logic                ovf
);

  logic [3:0] low;
  logic [1:0] high;
  logic       c3;

  // Split at the MSB so the carry into bit 3 is available for overflow detection.
  always_comb begin
    low  = {1'b0, a[2:0]} + {1'b0, ~b[2:0]} + {3'b000, cin};
    c3   = low[3];
    high = {1'b0, a[3]} + {1'b0, ~b[3]} + {1'b0, c3};
    diff = {high[0], low[2:0]};
    cout = high[1];
    ovf  = c3 ^ high[1];
  end

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle WIDTH-bit subtractor that runs one four_bit_sub slice over the operands, LS nibble first.
module nibble_serial_sub
  import nibble_serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic                            carry_q;
  logic [NIB-1:0][NIBBLE_W-1:0]    a_q;
  logic [NIB-1:0][NIBBLE_W-1:0]    b_q;
  logic [NIB-1:0][NIBBLE_W-1:0]    diff_acc;
  logic [NIB-1:0][NIBBLE_W-1:0]    acc_next;

  logic [NIBBLE_W-1:0] s_diff;
  logic                s_cout;
  logic                s_ovf;

  four_bit_sub u_slice (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .cin  (carry_q),
    .diff (s_diff),
    .cout (s_cout),
    .ovf  (s_ovf)
  );

  // Accumulator with the current nibble merged in, so the final edge can publish the full result.
  always_comb begin
    acc_next      = diff_acc;
    acc_next[idx] = s_diff;
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      diff_acc  <= '0;
      diff      <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= borrow_in;
            idx     <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          diff_acc <= acc_next;
          carry_q  <= s_cout;
          idx      <= idx + 1'b1;
          // Visible outputs change only here; partial nibbles never reach diff.
          if (idx == LAST_IDX) begin
            diff      <= acc_next;
            carry_out <= s_cout;
            overflow  <= s_ovf;
            zero      <= (acc_next == '0);
            negative  <= acc_next[NIB-1][NIBBLE_W-1];
            idx       <= '0;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub: directed scenarios plus randomized ops against an arithmetic model.
module tb_nibble_serial_sub;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] heldDiff = '0;

  nibble_serial_sub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum for diff/carry, signed integer range test for overflow.
  task automatic modelSub(input logic [WIDTH-1:0] av, bv, input logic bi,
                          output logic [WIDTH-1:0] ed, output logic ec, eo, ez, en);
    longint u;
    longint r;
    u  = longint'(av) + longint'((~bv) & 16'hFFFF) + longint'(bi);
    ed = u[WIDTH-1:0];
    ec = u[WIDTH];
    r  = longint'($signed(av)) - longint'($signed(bv)) - 1 + longint'(bi);
    eo = (r < -32768) || (r > 32767);
    ez = (ed == '0);
    en = ed[WIDTH-1];
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] av, bv, input logic bi);
    a = av; b = bv; borrow_in = bi; start = 1'b1;
    tick();
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); borrow_in = 1'($urandom);
    checkOutput("busy_after_accept", busy, 1);
  endtask

  task automatic waitDone(input string tag, input int expLat);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (n == 1) checkOutput({tag, "_held_diff"}, diff, heldDiff);
      tick();
      n++;
    end
    checkOutput({tag, "_latency"}, n, expLat);
  endtask

  task automatic checkResult(input string tag, input logic [WIDTH-1:0] av, bv, input logic bi);
    logic [WIDTH-1:0] ed;
    logic ec, eo, ez, en;
    modelSub(av, bv, bi, ed, ec, eo, ez, en);
    checkOutput({tag, "_diff"}, diff, ed);
    checkOutput({tag, "_carry"}, carry_out, ec);
    checkOutput({tag, "_ovf"}, overflow, eo);
    checkOutput({tag, "_zero"}, zero, ez);
    checkOutput({tag, "_neg"}, negative, en);
    heldDiff = ed;
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] av, bv, input logic bi);
    applyStimulus(av, bv, bi);
    waitDone(tag, NIB);
    checkResult(tag, av, bv, bi);
  endtask

  task automatic countDones(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    checkOutput({tag, "_done_count"}, seen, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    tick(); tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_diff", diff, 0);
    checkOutput("rst_flags", {carry_out, overflow, zero, negative}, 0);
    rst = 1'b0;
    tick();

    // Directed values from the plan, then the model-driven checks
    runOp("t1", 16'h1234, 16'h0034, 1'b1);
    checkOutput("t1_const", {diff, carry_out, overflow, zero, negative}, {16'h1200, 4'b1000});
    tick();
    runOp("t2a", 16'h0000, 16'h0001, 1'b1);
    checkOutput("t2a_const", {diff, carry_out, overflow, zero, negative}, {16'hFFFF, 4'b0001});
    tick();
    runOp("t2b", 16'h8000, 16'h0001, 1'b1);
    checkOutput("t2b_const", {diff, carry_out, overflow, zero, negative}, {16'h7FFF, 4'b1100});
    tick();
    runOp("t3a", 16'hABCD, 16'hABCD, 1'b1);
    checkOutput("t3a_const", {diff, carry_out, zero}, {16'h0000, 2'b11});
    tick();
    runOp("t3b", 16'h0005, 16'h0003, 1'b0);
    checkOutput("t3b_const", {diff, carry_out}, {16'h0001, 1'b1});
    tick();
    runOp("wrap", 16'h5A5A, 16'h5A5A, 1'b0);
    checkOutput("wrap_const", {diff, carry_out}, {16'hFFFF, 1'b0});
    tick();

    // Starts during RUN are dropped
    applyStimulus(16'h4000, 16'h0FFF, 1'b1);
    tick();
    a = 16'h1111; b = 16'h2222; borrow_in = 1'b0; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    waitDone("t4", NIB - 3);
    checkResult("t4", 16'h4000, 16'h0FFF, 1'b1);
    countDones("t4_single", 4);
    checkOutput("t4_idle_busy", busy, 0);

    // Back-to-back: second start issued in the DONE cycle
    runOp("t4b1", 16'h0F0F, 16'h00FF, 1'b1);
    runOp("t4b2", 16'h7FFF, 16'hFFFF, 1'b1);
    tick();

    // Reset in third RUN cycle aborts
    applyStimulus(16'h9999, 16'h1111, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_done", done, 0);
    checkOutput("t5_diff", diff, 0);
    checkOutput("t5_flags", {carry_out, overflow, zero, negative}, 0);
    countDones("t5_abort", 8);
    heldDiff = '0;
    runOp("t5_after", 16'h9999, 16'h1111, 1'b1);
    tick();

    // Randomized ops, sometimes back-to-back
    for (int i = 0; i < 1000; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic rbi;
      ra  = WIDTH'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
      rbi = 1'($urandom);
      runOp("rnd", ra, rb, rbi);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        checkOutput("rnd_idle", {busy, done}, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
